// File: rtl/mult_pkg.sv
// mult_pkg: shared widths, iteration limit and FSM encoding for the shift-add multiplier
package mult_pkg;
  localparam int WIDTH = 16;
  localparam int PROD_W = 32;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_ITER = 5'd15;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/sixteen_bit_ripple_carry_adder_module.sv
// sixteen_bit_ripple_carry_adder_module: 16-bit ripple-carry adder built from full-adder cells
module sixteen_bit_ripple_carry_adder_module (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [16:0] w_c;
  assign w_c[0] = cin;
  for (genvar i = 0; i < 16; i++) begin : g_fa
    assign sum[i] = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end
  assign cout = w_c[16];
endmodule

// File: rtl/shift_add_multiplier_module.sv
// shift_add_multiplier_module: sequential 16x16 unsigned multiplier, one add-and-shift per clock
module shift_add_multiplier_module #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  import mult_pkg::*;
  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] r_product;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic               w_accept;
  logic [2*WIDTH-1:0] w_next;
  assign w_accept = start && (r_state == IDLE || r_state == DONE);
  assign w_addend = r_lo[0] ? r_mcand : '0;
  assign w_next = {w_cout, w_sum, r_lo[WIDTH-1:1]};
  assign busy = r_state == RUN;
  assign done = r_state == DONE;
  assign product = r_product;
  sixteen_bit_ripple_carry_adder_module u_add (
    .a(r_hi),
    .b(w_addend),
    .cin(1'b0),
    .sum(w_sum),
    .cout(w_cout)
  );
  // FSM, iteration counter and accumulator; the adder carry becomes the new top bit each step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_mcand <= '0;
      r_hi <= '0;
      r_lo <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_mcand <= a;
      r_lo <= b;
      r_hi <= '0;
      r_cnt <= '0;
      r_state <= RUN;
    end else if (r_state == RUN) begin
      {r_hi, r_lo} <= w_next;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == LAST_ITER) begin
        r_state <= DONE;
        r_product <= w_next;
      end
    end else begin
      r_state <= IDLE;
    end
  end
endmodule
